demux_4b_1_4: RTL and testbench

DEMUX_4B_1_4 -- requirements
Module: demux_4b_1_4

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_dec_2to4.sv | 32 +++
 rtl/demux_4b_1_4.sv | 86 ++++++++
 tb/tb_demux_4b_1_4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1-to-4 registered demultiplexer.
//   DEFAULT_WIDTH : default data width of d and of every output y0..y3
//   NUM_OUTPUTS   : number of destinations (fixed at 4)
//   SEL_Y0..SEL_Y3: destination select codes driven on sel
//   vld_t         : one-hot strobe vector, bit i belongs to output yi
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int NUM_OUTPUTS   = 4;

  localparam logic [1:0] SEL_Y0 = 2'b00;
  localparam logic [1:0] SEL_Y1 = 2'b01;
  localparam logic [1:0] SEL_Y2 = 2'b10;
  localparam logic [1:0] SEL_Y3 = 2'b11;

  typedef logic [NUM_OUTPUTS-1:0] vld_t;

endpackage : demux_pkg

// File: rtl/demux_dec_2to4.sv
// -----------------------------------------------------------------------------
// demux_dec_2to4
// Combinational 2-to-4 one-hot decoder with enable. Its output is used both
// as the per-output load enable and as the next value of the vld strobe.
// Ports:
//   en  : in,  1 bit  - when 0 the output is all-zeros
//   sel : in,  2 bits - code to decode (SEL_Y0..SEL_Y3)
//   dec : out, 4 bits - one-hot code of sel when en=1, else 0000
// -----------------------------------------------------------------------------
module demux_dec_2to4
  import demux_pkg::*;
(
  input  logic       en,
  input  logic [1:0] sel,
  output vld_t       dec
);

  always_comb begin
    dec = '0;
    if (en) begin
      case (sel)
        SEL_Y0:  dec = 4'b0001;
        SEL_Y1:  dec = 4'b0010;
        SEL_Y2:  dec = 4'b0100;
        SEL_Y3:  dec = 4'b1000;
        // An unknown sel decodes to nothing; no defined routing is promised.
        default: dec = '0;
      endcase
    end
  end

endmodule : demux_dec_2to4

// File: rtl/demux_4b_1_4.sv
// -----------------------------------------------------------------------------
// demux_4b_1_4
// Registered 1-to-4 demultiplexer. On each rising clk edge with en=1 the data
// word d is written into the output register selected by sel, and vld carries
// the one-hot code of that destination for exactly the following cycle.
//
// Strobe semantics: vld is a pure valid strobe with no ready/back-pressure.
// vld[i]=1 during a cycle means yi was written on the edge that started this
// cycle; the consumer must take the data then or rely on the register holding
// it. At most one vld bit is ever high.
//
// Parameters:
//   WIDTH : data width of d and each output
//   HOLD  : 0 -> non-selected outputs are cleared on every enabled edge
//           1 -> non-selected outputs keep their last written value
// Ports:
//   clk    : in,  1 bit      - rising-edge clock
//   rst_n  : in,  1 bit      - asynchronous active-low reset
//   en     : in,  1 bit      - routing enable; 0 holds outputs, vld=0000
//   sel    : in,  2 bits     - destination select (00->y0 .. 11->y3)
//   d      : in,  WIDTH bits - data to route
//   y0..y3 : out, WIDTH bits - registered routed data
//   vld    : out, 4 bits     - one-hot write strobe
// -----------------------------------------------------------------------------
module demux_4b_1_4
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit HOLD  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       vld
);

  vld_t             load;
  logic [WIDTH-1:0] y_q [NUM_OUTPUTS];
  vld_t             vld_q;

  demux_dec_2to4 u_dec (
    .en  (en),
    .sel (sel),
    .dec (load)
  );

  // One WIDTH-bit register per destination. The clear of non-selected
  // outputs is gated by en so that an idle cycle never disturbs stored data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        y_q[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (load[i]) begin
          y_q[i] <= d;
        end else if (!HOLD) begin
          y_q[i] <= '0;
        end
      end
    end
  end

  // The decoder already yields 0000 when en=0, so vld simply registers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= load;
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign vld = vld_q;

endmodule : demux_4b_1_4

// File: tb/tb_demux_4b_1_4.sv
// -----------------------------------------------------------------------------
// tb_demux_4b_1_4
// Drives one HOLD=0 and one HOLD=1 instance of demux_4b_1_4 with shared inputs
// and compares both against a behavioural model of four destination slots.
// -----------------------------------------------------------------------------
module tb_demux_4b_1_4;

  localparam int W  = 4;
  localparam int EW = 8 * W + 4;  // hold0 ys, hold1 ys, vld

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         en  = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic [W-1:0] d   = '0;

  logic [W-1:0] a_y0, a_y1, a_y2, a_y3;
  logic [3:0]   a_vld;
  logic [W-1:0] b_y0, b_y1, b_y2, b_y3;
  logic [3:0]   b_vld;

  demux_4b_1_4 #(.WIDTH(W), .HOLD(1'b0)) dut_clr (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d),
    .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3), .vld(a_vld)
  );

  demux_4b_1_4 #(.WIDTH(W), .HOLD(1'b1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d),
    .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3), .vld(b_vld)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // Model: four slots per mode plus the strobe of the last edge.
  logic [W-1:0] m_clr [4];
  logic [W-1:0] m_hold[4];
  logic [3:0]   m_vld;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_clr[i]  = '0;
      m_hold[i] = '0;
    end
    m_vld = '0;
  endtask

  // Apply the routing rule for one edge and queue the expected state.
  task automatic model_edge(input logic e, input logic [1:0] s, input logic [W-1:0] dv);
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        m_clr[i] = (i == int'(s)) ? dv : '0;
        if (i == int'(s)) m_hold[i] = dv;
      end
      m_vld = 4'(1 << s);
    end else begin
      m_vld = '0;
    end
    exp_q.push_back({m_clr[3], m_clr[2], m_clr[1], m_clr[0],
                     m_hold[3], m_hold[2], m_hold[1], m_hold[0], m_vld});
  endtask

  task automatic check_now(input logic [EW-1:0] e);
    logic [W-1:0] ev;
    ev = e[3:0];
    check("clr_y0",  a_y0,  e[4*W+4+0*W +: W]);
    check("clr_y1",  a_y1,  e[4*W+4+1*W +: W]);
    check("clr_y2",  a_y2,  e[4*W+4+2*W +: W]);
    check("clr_y3",  a_y3,  e[4*W+4+3*W +: W]);
    check("hold_y0", b_y0,  e[4+0*W +: W]);
    check("hold_y1", b_y1,  e[4+1*W +: W]);
    check("hold_y2", b_y2,  e[4+2*W +: W]);
    check("hold_y3", b_y3,  e[4+3*W +: W]);
    check("clr_vld",  a_vld, ev);
    check("hold_vld", b_vld, ev);
    check("vld_onehot", 4'($countones(a_vld) <= 1 && $countones(b_vld) <= 1), 4'd1);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic [1:0] s, input logic [W-1:0] dv);
    @(negedge clk);
    en  = e;
    sel = s;
    d   = dv;
    model_edge(e, s, dv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      check_now(exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] walk [4];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now({EW{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;

    // First enabled edge after reset routes normally.
    step(1'b1, 2'b00, 4'b0101);

    // Walk the select with constant data.
    walk[0] = 2'b01; walk[1] = 2'b10; walk[2] = 2'b11; walk[3] = 2'b01;
    for (int i = 0; i < 4; i++) step(1'b1, walk[i], 4'b0101);

    // Two destinations, HOLD=1 keeps both.
    step(1'b1, 2'b00, 4'b0101);
    step(1'b1, 2'b10, 4'b1010);

    // Disabled cycles: outputs hold, strobe silent.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 4'b1111);

    // Data changing under a constant select.
    step(1'b1, 2'b01, 4'b0011);
    step(1'b1, 2'b01, 4'b0101);

    // Asynchronous reset between edges while y1=0101.
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_y1",  a_y1,  4'b0000);
    check("async_hold_y1", b_y1,  4'b0000);
    check("async_clr_vld", a_vld, 4'b0000);
    check("async_hold_vld", b_vld, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    check_now({EW{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b11, 4'b1001);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule : tb_demux_4b_1_4
